// File: rtl/soft_fifo_thresh.sv
// Show-ahead flip-flop FIFO with almost-full/almost-empty thresholds,
// sticky overflow/underflow flags and a peak-occupancy tracker.
module soft_fifo_thresh #(
  parameter int WIDTH     = 32,
  parameter int LOG_DEPTH = 4,
  parameter int AF_THRESH = (1 << LOG_DEPTH) - 1,
  parameter int AE_THRESH = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 wrreq,
  input  logic [WIDTH-1:0]     data,
  input  logic                 rdreq,
  input  logic                 err_clear,
  output logic [WIDTH-1:0]     q,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [LOG_DEPTH:0]   usedw,
  output logic [LOG_DEPTH:0]   peak_usedw,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int DEPTH = 1 << LOG_DEPTH;
  localparam int PTR_W = (LOG_DEPTH > 0) ? LOG_DEPTH : 1;
  localparam int CNT_W = LOG_DEPTH + 1;

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_LVL   = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_LVL   = CNT_W'(AE_THRESH);
  localparam logic [PTR_W-1:0] PTR_ZERO = '0;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] usedw_reg, usedw_next;
  logic [CNT_W-1:0] peak_reg, peak_next;
  logic             overflow_reg, overflow_next;
  logic             underflow_reg, underflow_next;

  logic             rd_acc, wr_acc, rd_en, wr_en;
  logic             ovf_evt, udf_evt;
  logic [WIDTH-1:0] entry_view [DEPTH];

  assign full         = (usedw_reg == CNT_FULL);
  assign empty        = (usedw_reg == CNT_ZERO);
  assign almost_full  = (usedw_reg >= AF_LVL);
  assign almost_empty = (usedw_reg <= AE_LVL);

  assign rd_acc = rdreq & ~empty;
  assign wr_acc = wrreq & (~full | rd_acc);

  // Flush squashes the request entirely; reset additionally blocks the array write.
  assign rd_en   = rd_acc & ~flush;
  assign wr_en   = wr_acc & ~flush & ~reset;
  assign ovf_evt = wrreq & full & ~rd_acc & ~flush;
  assign udf_evt = rdreq & empty & ~flush;

  always_comb begin
    wr_ptr_next    = wr_ptr_reg;
    rd_ptr_next    = rd_ptr_reg;
    usedw_next     = usedw_reg;
    peak_next      = peak_reg;
    overflow_next  = (overflow_reg & ~err_clear) | ovf_evt;
    underflow_next = (underflow_reg & ~err_clear) | udf_evt;

    if (flush) begin
      wr_ptr_next = PTR_ZERO;
      rd_ptr_next = PTR_ZERO;
      usedw_next  = CNT_ZERO;
    end else begin
      if (wr_acc)
        wr_ptr_next = (wr_ptr_reg == PTR_LAST) ? PTR_ZERO : wr_ptr_reg + PTR_ONE;
      if (rd_en)
        rd_ptr_next = (rd_ptr_reg == PTR_LAST) ? PTR_ZERO : rd_ptr_reg + PTR_ONE;
      case ({wr_acc, rd_en})
        2'b10:   usedw_next = usedw_reg + CNT_ONE;
        2'b01:   usedw_next = usedw_reg - CNT_ONE;
        default: usedw_next = usedw_reg;
      endcase
    end

    // err_clear restarts the peak from the occupancy about to be registered.
    if (err_clear)
      peak_next = usedw_next;
    else if (usedw_next > peak_reg)
      peak_next = usedw_next;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_reg    <= PTR_ZERO;
      rd_ptr_reg    <= PTR_ZERO;
      usedw_reg     <= CNT_ZERO;
      peak_reg      <= CNT_ZERO;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      usedw_reg     <= usedw_next;
      peak_reg      <= peak_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  // Storage is plain registers with no reset; only the addressed entry loads.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [WIDTH-1:0] entry_reg;

    always_ff @(posedge clock) begin
      if (wr_en && (wr_ptr_reg == PTR_W'(gi)))
        entry_reg <= data;
    end

    assign entry_view[gi] = entry_reg;
  end

  assign q          = entry_view[rd_ptr_reg];
  assign usedw      = usedw_reg;
  assign peak_usedw = peak_reg;
  assign overflow   = overflow_reg;
  assign underflow  = underflow_reg;

endmodule

// File: doc/soft_fifo_thresh.md
SOFT_FIFO_THRESH -- requirements
Module: soft_fifo_thresh

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width in bits (>=1).
REQ-002 SHALL have parameter LOG_DEPTH, default 4, storage depth DEPTH = 2^LOG_DEPTH entries (>=1).
REQ-003 SHALL have parameter AF_THRESH, default DEPTH-1, almost-full level (1..DEPTH).
REQ-004 SHALL have parameter AE_THRESH, default 1, almost-empty level (0..DEPTH-1).
REQ-005 SHALL have port clock  input  1  sole clock, all state on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port flush  input  1  synchronous discard of all stored entries.
REQ-008 SHALL have port wrreq  input  1  enqueue request.
REQ-009 SHALL have port data  input  WIDTH  enqueue data.
REQ-010 SHALL have port rdreq  input  1  dequeue request.
REQ-011 SHALL have port err_clear  input  1  clears sticky flags and peak level.
REQ-012 SHALL have port q  output  WIDTH  head entry, show-ahead.
REQ-013 SHALL have port full / empty  output  1 each  occupancy == DEPTH / == 0.
REQ-014 SHALL have port almost_full / almost_empty  output  1 each  threshold flags.
REQ-015 SHALL have port usedw  output  LOG_DEPTH+1  current occupancy 0..DEPTH.
REQ-016 SHALL have port peak_usedw  output  LOG_DEPTH+1  highest occupancy since last clear.
REQ-017 SHALL have port overflow / underflow  output  1 each  sticky error flags.

Function
REQ-018 SHALL store entries in flip-flop array (no block RAM); single clock domain.
REQ-019 SHALL define rd_acc = rdreq & !empty; wr_acc = wrreq & (!full | rd_acc).
REQ-020 SHALL accept a write while full only when a read is accepted same cycle; occupancy unchanged.
REQ-021 SHALL NOT accept a read while empty even if a write is accepted same cycle (no fall-through).
REQ-022 SHALL update usedw next cycle: +1 write only, -1 read only, unchanged both/neither.
REQ-023 SHALL advance wr_ptr / rd_ptr by 1 mod DEPTH on each accepted write / read; natural wrap.
REQ-024 SHALL drive q = entry at rd_ptr combinationally; q undefined-content but stable when empty.
REQ-025 SHALL write data into array only on wr_acc; array never reset.
REQ-026 SHALL derive full, empty, almost_full (usedw >= AF_THRESH), almost_empty (usedw <= AE_THRESH) combinationally from registered usedw.
REQ-027 SHALL set overflow on the cycle after wrreq & full & !rd_acc; sticky until err_clear or reset.
REQ-028 SHALL set underflow on the cycle after rdreq & empty; sticky until err_clear or reset.
REQ-029 SHALL update peak_usedw to max(peak_usedw, next usedw) each cycle.
REQ-030 SHALL, on err_clear, clear overflow/underflow and load peak_usedw with next usedw; a same-cycle new error event wins (flag set).
REQ-031 SHALL, on flush, zero usedw, rd_ptr, wr_ptr next cycle; flush overrides same-cycle wrreq/rdreq (no write, no error flags raised).
REQ-032 SHALL leave overflow, underflow, peak_usedw unaffected by flush.
REQ-033 SHALL give one-cycle latency from accepted write to empty deasserting and q valid.

Reset
REQ-034 SHALL, on reset high at clock edge, zero usedw, rd_ptr, wr_ptr, peak_usedw, overflow, underflow; reset overrides flush, err_clear, wrreq, rdreq.
REQ-035 SHALL present after reset: empty=1, full=0, almost_empty=1, almost_full=0, usedw=0.
REQ-036 SHALL discard in-flight contents when reset asserted mid-operation; no write occurs that cycle.

Verification (WIDTH=8, LOG_DEPTH=2, AF_THRESH=3, AE_THRESH=1)
REQ-037 SHALL test fill: write 0x11,0x22,0x33,0x44 -> usedw 1,2,3,4; almost_empty drops at 2; almost_full at 3; full at 4; peak_usedw=4; q=0x11.
REQ-038 SHALL test full overflow: full, wrreq=1 data 0x55, rdreq=0 -> overflow=1, usedw=4, drained order 0x11,0x22,0x33,0x44.
REQ-039 SHALL test full pass-through: full, wrreq+rdreq data 0x66 -> usedw=4, overflow stays 0, drain order 0x22,0x33,0x44,0x66.
REQ-040 SHALL test empty read: empty, rdreq+wrreq data 0x77 -> underflow=1, usedw=1, q=0x77 next cycle.
REQ-041 SHALL test wrap: 10 interleaved write/read pairs of 0x00..0x09 -> output order 0x00..0x09, usedw never >1.
REQ-042 SHALL test flush/reset: usedw=3, flush+wrreq -> usedw=0, empty=1, peak_usedw kept; then reset -> peak_usedw=0, flags 0.
